// File: rtl/rf_ldst_pkg.sv
// Shared types and default widths for the register-file load/store engine.
package rf_ldst_pkg;

   localparam int RF_ADDR_W_DEF    = 10;
   localparam int LINE_NUM_W_DEF   = 8;
   localparam int SDRAM_ADDR_W_DEF = 32;
   localparam int LINE_W_DEF       = 128;

   // Bytes covered by one line on the SDRAM side.
   localparam int LINE_BYTES = LINE_W_DEF / 8;

   typedef enum logic [2:0] {
      IDLE,
      LD_REQ,
      LD_WAIT,
      ST_RD,
      ST_REQ,
      DONE
   } state_t;

endpackage

// File: rtl/ldst_addr_gen.sv
// Address and remaining-line bookkeeping for one transfer: loaded at start,
// stepped once per completed line.
module ldst_addr_gen
   import rf_ldst_pkg::*;
#(
   parameter int RF_ADDR_W    = RF_ADDR_W_DEF,
   parameter int LINE_NUM_W   = LINE_NUM_W_DEF,
   parameter int SDRAM_ADDR_W = SDRAM_ADDR_W_DEF,
   parameter int STEP         = LINE_BYTES
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_load,
   input  logic                    i_step,
   input  logic [RF_ADDR_W-1:0]    i_rf_addr,
   input  logic [SDRAM_ADDR_W-1:0] i_sd_addr,
   input  logic [LINE_NUM_W-1:0]   i_count,
   output logic [RF_ADDR_W-1:0]    o_rf_addr,
   output logic [SDRAM_ADDR_W-1:0] o_sd_addr,
   output logic                    o_last,
   output logic                    o_empty
);

   logic [RF_ADDR_W-1:0]    r_rf_addr;
   logic [SDRAM_ADDR_W-1:0] r_sd_addr;
   logic [LINE_NUM_W-1:0]   r_count;

   // Capture operands on load; advance both addresses (natural wrap) and
   // consume one line on each step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rf_addr <= '0;
         r_sd_addr <= '0;
         r_count   <= '0;
      end else if (i_load) begin
         r_rf_addr <= i_rf_addr;
         r_sd_addr <= i_sd_addr;
         r_count   <= i_count;
      end else if (i_step) begin
         r_rf_addr <= r_rf_addr + RF_ADDR_W'(1);
         r_sd_addr <= r_sd_addr + SDRAM_ADDR_W'(STEP);
         r_count   <= r_count - LINE_NUM_W'(1);
      end
   end

   assign o_rf_addr = r_rf_addr;
   assign o_sd_addr = r_sd_addr;
   assign o_last    = (r_count == LINE_NUM_W'(1));
   assign o_empty   = (r_count == '0);

endmodule

// File: rtl/rf_ldst_engine.sv
// Moves lines between the register file and SDRAM, one outstanding SDRAM
// request at a time. Starts are registered in IDLE and acted on a cycle later.
module rf_ldst_engine
   import rf_ldst_pkg::*;
#(
   parameter int RF_ADDR_W    = RF_ADDR_W_DEF,
   parameter int LINE_NUM_W   = LINE_NUM_W_DEF,
   parameter int SDRAM_ADDR_W = SDRAM_ADDR_W_DEF,
   parameter int LINE_W       = LINE_W_DEF
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load_start,
   input  logic                    store_start,
   input  logic [RF_ADDR_W-1:0]    rf_addr,
   input  logic [SDRAM_ADDR_W-1:0] sdram_addr,
   input  logic [LINE_NUM_W-1:0]   line_num,
   output logic                    busy,
   output logic                    done,
   output logic                    rf_we,
   output logic [RF_ADDR_W-1:0]    rf_waddr,
   output logic [LINE_W-1:0]       rf_wdata,
   output logic                    rf_re,
   output logic [RF_ADDR_W-1:0]    rf_raddr,
   input  logic [LINE_W-1:0]       rf_rdata,
   output logic                    sd_req,
   output logic                    sd_we,
   output logic [SDRAM_ADDR_W-1:0] sd_addr,
   output logic [LINE_W-1:0]       sd_wdata,
   input  logic                    sd_ready,
   input  logic                    sd_rvalid,
   input  logic [LINE_W-1:0]       sd_rdata
);

   state_t                  r_state;
   state_t                  w_state_next;
   logic                    r_pend;       // a start was sampled last cycle
   logic                    r_is_load;    // load wins when both starts are high
   logic                    r_rd_phase;   // second cycle of ST_RD: RF data valid
   logic [LINE_W-1:0]       r_sd_wdata;

   logic                    w_gen_load;
   logic                    w_gen_step;
   logic                    w_last;
   logic                    w_empty;
   logic [RF_ADDR_W-1:0]    w_rf_addr;
   logic [SDRAM_ADDR_W-1:0] w_sd_addr;

   // Starts are only looked at while idle and not already holding one.
   assign w_gen_load = (r_state == IDLE) && !r_pend && (load_start || store_start);

   ldst_addr_gen #(
      .RF_ADDR_W    (RF_ADDR_W),
      .LINE_NUM_W   (LINE_NUM_W),
      .SDRAM_ADDR_W (SDRAM_ADDR_W),
      .STEP         (LINE_W / 8)
   ) u_addr_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_load    (w_gen_load),
      .i_step    (w_gen_step),
      .i_rf_addr (rf_addr),
      .i_sd_addr (sdram_addr),
      .i_count   (line_num),
      .o_rf_addr (w_rf_addr),
      .o_sd_addr (w_sd_addr),
      .o_last    (w_last),
      .o_empty   (w_empty)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_next;
   end

   // Start latch, RF read phase and store-data capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend     <= 1'b0;
         r_is_load  <= 1'b0;
         r_rd_phase <= 1'b0;
         r_sd_wdata <= '0;
      end else begin
         r_pend <= w_gen_load;
         if (w_gen_load) r_is_load <= load_start;
         r_rd_phase <= (r_state == ST_RD) && !r_rd_phase;
         if ((r_state == ST_RD) && r_rd_phase) r_sd_wdata <= rf_rdata;
      end
   end

   // Next-state and handshake outputs.
   always_comb begin
      w_state_next = r_state;
      busy         = 1'b1;
      done         = 1'b0;
      rf_we        = 1'b0;
      rf_re        = 1'b0;
      sd_req       = 1'b0;
      sd_we        = 1'b0;
      w_gen_step   = 1'b0;
      case (r_state)
         IDLE: begin
            busy = 1'b0;
            if (r_pend) w_state_next = w_empty ? DONE : (r_is_load ? LD_REQ : ST_RD);
         end
         LD_REQ: begin
            sd_req = 1'b1;
            if (sd_ready) w_state_next = LD_WAIT;
         end
         LD_WAIT: begin
            if (sd_rvalid) begin
               rf_we        = 1'b1;
               w_gen_step   = 1'b1;
               w_state_next = w_last ? DONE : LD_REQ;
            end
         end
         ST_RD: begin
            rf_re = !r_rd_phase;
            if (r_rd_phase) w_state_next = ST_REQ;
         end
         ST_REQ: begin
            sd_req = 1'b1;
            sd_we  = 1'b1;
            if (sd_ready) begin
               w_gen_step   = 1'b1;
               w_state_next = w_last ? DONE : ST_RD;
            end
         end
         DONE: begin
            done         = 1'b1;
            w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   assign rf_waddr = w_rf_addr;
   assign rf_raddr = w_rf_addr;
   assign rf_wdata = rf_we ? sd_rdata : '0;
   assign sd_addr  = w_sd_addr;
   assign sd_wdata = r_sd_wdata;

endmodule

// File: tb/tb_rf_ldst_engine.sv
// Bench for rf_ldst_engine: SDRAM and RF models, a transaction monitor, and
// per-scenario tasks comparing observed traffic against expected traffic.
module tb_rf_ldst_engine;

   localparam int RAW = 10;
   localparam int LNW = 8;
   localparam int SAW = 32;
   localparam int LW  = 128;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           load_start = 1'b0;
   logic           store_start = 1'b0;
   logic [RAW-1:0] rf_addr = '0;
   logic [SAW-1:0] sdram_addr = '0;
   logic [LNW-1:0] line_num = '0;
   logic           busy, done, rf_we, rf_re, sd_req, sd_we;
   logic [RAW-1:0] rf_waddr, rf_raddr;
   logic [LW-1:0]  rf_wdata, sd_wdata;
   logic [SAW-1:0] sd_addr;
   logic [LW-1:0]  rf_rdata = '0;
   logic [LW-1:0]  sd_rdata = '0;
   logic           sd_ready = 1'b0;
   logic           sd_rvalid = 1'b0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   rf_ldst_engine dut (
      .clk(clk), .rst_n(rst_n), .load_start(load_start), .store_start(store_start),
      .rf_addr(rf_addr), .sdram_addr(sdram_addr), .line_num(line_num),
      .busy(busy), .done(done), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .rf_re(rf_re), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
      .sd_req(sd_req), .sd_we(sd_we), .sd_addr(sd_addr), .sd_wdata(sd_wdata),
      .sd_ready(sd_ready), .sd_rvalid(sd_rvalid), .sd_rdata(sd_rdata)
   );

   // ---------------- environment state ----------------
   logic [LW-1:0]  rf_mem [0:1023];
   int cyc = 0;
   int ready_mode = 1;       // 1: always ready, 0: random
   int lat_fixed = 0;        // 0: random read latency 1..3
   bit spur_en = 0;          // inject unsolicited sd_rvalid pulses
   int bp_at = -1;           // stall the request that follows this many accepts
   int bp_left = 0;
   int rv_cnt = 0;
   int n_acc = 0, n_stall = 0, done_cnt = 0, done_cyc = 0;
   int viol_both = 0, viol_outst = 0, viol_stable = 0, viol_done = 0;
   bit mon_re = 0, mon_rd_acc = 0;
   logic [RAW-1:0] mon_raddr = '0;
   bit rd_out = 0, prev_stall = 0, prev_done = 0;
   logic [SAW-1:0] prev_addr = '0;
   logic           prev_we = 1'b0;
   logic [LW-1:0]  prev_wdata = '0;

   logic [SAW-1:0] q_sd_addr[$];
   logic           q_sd_we[$];
   logic [LW-1:0]  q_sd_wdata[$];
   logic [RAW-1:0] q_rfw_addr[$];
   logic [LW-1:0]  q_rfw_data[$];
   logic [RAW-1:0] q_rfr_addr[$];
   logic [LW-1:0]  q_resp[$];

   function automatic logic [LW-1:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Monitor: mid-cycle view of what happens at the next rising edge.
   always @(negedge clk) begin
      mon_re = 0;
      mon_rd_acc = 0;
      if (!rst_n) begin
         rd_out = 0; prev_stall = 0; prev_done = 0;
      end else begin
         if (rf_we && rf_re) viol_both++;
         if (sd_req && rd_out) viol_outst++;
         if (prev_stall && (!sd_req || sd_addr !== prev_addr || sd_we !== prev_we ||
                            (sd_we && sd_wdata !== prev_wdata))) viol_stable++;
         if (done && prev_done) viol_done++;
         prev_done = done;
         if (done) begin done_cnt++; done_cyc = cyc; end
         if (sd_rvalid && rd_out) rd_out = 0;
         if (rf_we) begin q_rfw_addr.push_back(rf_waddr); q_rfw_data.push_back(rf_wdata); end
         if (rf_re) begin q_rfr_addr.push_back(rf_raddr); mon_re = 1; mon_raddr = rf_raddr; end
         if (sd_req && sd_ready) begin
            q_sd_addr.push_back(sd_addr); q_sd_we.push_back(sd_we); q_sd_wdata.push_back(sd_wdata);
            n_acc++;
            if (!sd_we) begin rd_out = 1; mon_rd_acc = 1; end
         end
         if (sd_req && !sd_ready) n_stall++;
         prev_stall = sd_req && !sd_ready;
         prev_addr = sd_addr; prev_we = sd_we; prev_wdata = sd_wdata;
      end
   end

   // SDRAM and RF models, driven just after each rising edge.
   always @(posedge clk) begin
      cyc++;
      #1;
      rf_rdata  = mon_re ? rf_mem[mon_raddr] : rand128();
      sd_rvalid = 1'b0;
      sd_rdata  = rand128();
      if (mon_rd_acc) rv_cnt = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 3));
      if (rv_cnt > 0) begin
         rv_cnt--;
         if (rv_cnt == 0) begin sd_rvalid = 1'b1; q_resp.push_back(sd_rdata); end
      end else if (spur_en && $urandom_range(0, 3) == 0) begin
         sd_rvalid = 1'b1;
      end
      sd_ready = (ready_mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (bp_left > 0 && n_acc == bp_at && sd_req) begin sd_ready = 1'b0; bp_left--; end
   end

   task automatic clear_env();
      q_sd_addr.delete(); q_sd_we.delete(); q_sd_wdata.delete();
      q_rfw_addr.delete(); q_rfw_data.delete(); q_rfr_addr.delete(); q_resp.delete();
      n_acc = 0; n_stall = 0; bp_at = -1; bp_left = 0;
   endtask

   task automatic start_op(input bit ld, input bit st, input logic [RAW-1:0] rfa,
                           input logic [SAW-1:0] sda, input logic [LNW-1:0] n, output int sc);
      @(posedge clk); #1;
      load_start = ld; store_start = st; rf_addr = rfa; sdram_addr = sda; line_num = n;
      sc = cyc;
      @(posedge clk); #1;
      load_start = 0; store_start = 0;
      rf_addr = RAW'($urandom); sdram_addr = $urandom; line_num = LNW'($urandom);
   endtask

   task automatic wait_done(input int d0, input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk); #1;
         if (done_cnt != d0) begin ok = 1; break; end
      end
      repeat (8) @(posedge clk);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if ({busy, done, rf_we, rf_re, sd_req, sd_we} !== 6'b0) begin
         failures++; $display("FAIL reset_ctrl got=%b want=000000", {busy, done, rf_we, rf_re, sd_req, sd_we});
      end
      checks++;
      if (sd_addr !== '0 || rf_waddr !== '0 || sd_wdata !== '0 || rf_wdata !== '0) begin
         failures++; $display("FAIL reset_data sd_addr=%h rf_waddr=%h sd_wdata=%h rf_wdata=%h want=0", sd_addr, rf_waddr, sd_wdata, rf_wdata);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      $display("test_reset done");
   endtask

   task automatic test_load();
      int d0, sc; bit ok;
      clear_env(); ready_mode = 1; lat_fixed = 2; spur_en = 0;
      d0 = done_cnt;
      start_op(1, 0, 10'h010, 32'h1000, 8'd3, sc);
      wait_done(d0, 200, ok);
      checks++; if (!ok) begin failures++; $display("FAIL load_timeout got=no_done want=done"); end
      checks++; if (q_sd_addr.size() != 3 || q_rfw_addr.size() != 3 || q_resp.size() != 3) begin
         failures++; $display("FAIL load_counts sd=%0d rfw=%0d resp=%0d want=3/3/3", q_sd_addr.size(), q_rfw_addr.size(), q_resp.size());
      end
      for (int i = 0; i < 3 && i < q_sd_addr.size(); i++) begin
         checks++;
         if (q_sd_addr[i] !== 32'h1000 + 32'(16 * i) || q_sd_we[i] !== 1'b0) begin
            failures++; $display("FAIL load_sd_req[%0d] got=%h/we%b want=%h/we0", i, q_sd_addr[i], q_sd_we[i], 32'h1000 + 32'(16 * i));
         end
      end
      for (int i = 0; i < 3 && i < q_rfw_addr.size() && i < q_resp.size(); i++) begin
         checks++;
         if (q_rfw_addr[i] !== 10'h010 + 10'(i) || q_rfw_data[i] !== q_resp[i]) begin
            failures++; $display("FAIL load_rf_wr[%0d] got=%h:%h want=%h:%h", i, q_rfw_addr[i], q_rfw_data[i], 10'h010 + 10'(i), q_resp[i]);
         end
      end
      checks++; if (done_cnt - d0 != 1 || q_rfr_addr.size() != 0) begin
         failures++; $display("FAIL load_done got=%0d rfreads=%0d want=1/0", done_cnt - d0, q_rfr_addr.size());
      end
      $display("test_load rf=010 sd=1000 n=3 writes=%0d", q_rfw_addr.size());
   endtask

   task automatic test_store(input bit with_bp);
      int d0, sc, st0, vs0; bit ok;
      logic [RAW-1:0] rfa, ea;
      logic [SAW-1:0] sda;
      clear_env(); ready_mode = 1; lat_fixed = 0; spur_en = 0;
      rfa = with_bp ? 10'h100 : 10'h3FE;
      sda = with_bp ? 32'h0000_8000 : 32'h0000_2000;
      if (with_bp) begin bp_at = 1; bp_left = 5; end
      d0 = done_cnt; st0 = n_stall; vs0 = viol_stable;
      start_op(0, 1, rfa, sda, 8'd3, sc);
      wait_done(d0, 200, ok);
      checks++; if (!ok) begin failures++; $display("FAIL store_timeout bp=%0b got=no_done want=done", with_bp); end
      checks++; if (q_sd_addr.size() != 3 || q_rfr_addr.size() != 3 || q_rfw_addr.size() != 0) begin
         failures++; $display("FAIL store_counts bp=%0b sd=%0d rfr=%0d rfw=%0d want=3/3/0", with_bp, q_sd_addr.size(), q_rfr_addr.size(), q_rfw_addr.size());
      end
      for (int i = 0; i < 3 && i < q_rfr_addr.size(); i++) begin
         ea = rfa + 10'(i);
         checks++;
         if (q_rfr_addr[i] !== ea) begin
            failures++; $display("FAIL store_rf_rd[%0d] got=%h want=%h", i, q_rfr_addr[i], ea);
         end
      end
      for (int i = 0; i < 3 && i < q_sd_addr.size(); i++) begin
         ea = rfa + 10'(i);
         checks++;
         if (q_sd_addr[i] !== sda + 32'(16 * i) || q_sd_we[i] !== 1'b1 || q_sd_wdata[i] !== rf_mem[ea]) begin
            failures++; $display("FAIL store_sd_wr[%0d] got=%h/we%b/%h want=%h/we1/%h", i, q_sd_addr[i], q_sd_we[i], q_sd_wdata[i], sda + 32'(16 * i), rf_mem[ea]);
         end
      end
      checks++; if (done_cnt - d0 != 1) begin
         failures++; $display("FAIL store_done got=%0d want=1", done_cnt - d0);
      end
      if (with_bp) begin
         checks++; if (n_stall - st0 != 5 || viol_stable != vs0) begin
            failures++; $display("FAIL bp_stall got=%0d unstable=%0d want=5/0", n_stall - st0, viol_stable - vs0);
         end
      end
      $display("test_store bp=%0b rf=%h sd=%h n=3 sd_writes=%0d", with_bp, rfa, sda, q_sd_addr.size());
   endtask

   task automatic test_zero_len();
      int d0, sc; bit ok;
      for (int k = 0; k < 2; k++) begin
         clear_env(); ready_mode = 1; spur_en = 0;
         d0 = done_cnt;
         start_op(k == 0, k == 1, RAW'($urandom), $urandom, 8'd0, sc);
         wait_done(d0, 20, ok);
         checks++; if (!ok || done_cyc - sc != 2) begin
            failures++; $display("FAIL zero_len_latency[%0d] got=%0d want=2", k, done_cyc - sc);
         end
         checks++; if (done_cnt - d0 != 1 || q_sd_addr.size() != 0 || n_stall != 0 ||
                       q_rfw_addr.size() != 0 || q_rfr_addr.size() != 0) begin
            failures++; $display("FAIL zero_len_traffic[%0d] done=%0d sd=%0d stall=%0d rfw=%0d rfr=%0d want=1/0/0/0/0", k, done_cnt - d0, q_sd_addr.size(), n_stall, q_rfw_addr.size(), q_rfr_addr.size());
         end
         $display("test_zero_len kind=%0d latency=%0d", k, done_cyc - sc);
      end
   endtask

   task automatic test_simultaneous();
      int d0, sc; bit ok, seen;
      clear_env(); ready_mode = 1; lat_fixed = 3; spur_en = 0;
      d0 = done_cnt;
      start_op(1, 1, 10'h020, 32'h4000, 8'd3, sc);
      seen = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         if (n_acc >= 1) begin seen = 1; break; end
      end
      checks++; if (!seen) begin failures++; $display("FAIL simul_first_req got=none want=accept"); end
      store_start = 1; rf_addr = 10'h200; sdram_addr = 32'h9000; line_num = 8'd2;
      @(posedge clk); #1;
      store_start = 0;
      wait_done(d0, 200, ok);
      repeat (20) @(posedge clk);
      checks++; if (!ok || done_cnt - d0 != 1) begin
         failures++; $display("FAIL simul_done got=%0d want=1", done_cnt - d0);
      end
      checks++; if (q_sd_addr.size() != 3 || q_rfr_addr.size() != 0 || q_rfw_addr.size() != 3) begin
         failures++; $display("FAIL simul_counts sd=%0d rfr=%0d rfw=%0d want=3/0/3", q_sd_addr.size(), q_rfr_addr.size(), q_rfw_addr.size());
      end
      for (int i = 0; i < 3 && i < q_sd_addr.size() && i < q_rfw_addr.size(); i++) begin
         checks++;
         if (q_sd_we[i] !== 1'b0 || q_sd_addr[i] !== 32'h4000 + 32'(16 * i) || q_rfw_addr[i] !== 10'h020 + 10'(i)) begin
            failures++; $display("FAIL simul_line[%0d] got=we%b/%h/%h want=we0/%h/%h", i, q_sd_we[i], q_sd_addr[i], q_rfw_addr[i], 32'h4000 + 32'(16 * i), 10'h020 + 10'(i));
         end
      end
      $display("test_simultaneous load_lines=%0d", q_rfw_addr.size());
   endtask

   task automatic test_reset_mid();
      int d0, sc; bit seen;
      clear_env(); ready_mode = 1; lat_fixed = 3; spur_en = 0;
      d0 = done_cnt;
      start_op(1, 0, 10'h050, 32'h6000, 8'd4, sc);
      seen = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         if (n_acc >= 1) begin seen = 1; break; end
      end
      checks++; if (!seen || busy !== 1'b1) begin failures++; $display("FAIL rst_mid_setup got=busy%b want=busy1", busy); end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, rf_we, rf_re, sd_req, sd_we} !== 6'b0 || sd_addr !== '0 || rf_waddr !== '0 || rf_wdata !== '0) begin
         failures++; $display("FAIL rst_mid_outputs ctrl=%b sd_addr=%h rf_waddr=%h want=0", {busy, done, rf_we, rf_re, sd_req, sd_we}, sd_addr, rf_waddr);
      end
      clear_env();
      @(posedge clk); #1;
      rst_n = 1'b1;
      spur_en = 1;
      repeat (15) @(posedge clk);
      spur_en = 0;
      #1;
      checks++; if (q_rfw_addr.size() != 0 || done_cnt != d0 || busy !== 1'b0 || q_sd_addr.size() != 0) begin
         failures++; $display("FAIL rst_mid_after rfw=%0d done=%0d busy=%b sd=%0d want=0/0/0/0", q_rfw_addr.size(), done_cnt - d0, busy, q_sd_addr.size());
      end
      $display("test_reset_mid late_rvalid_writes=%0d", q_rfw_addr.size());
   endtask

   task automatic test_random();
      int d0, sc, n, errs; bit ok, ld;
      logic [RAW-1:0] rfa, ea;
      logic [SAW-1:0] sda, es;
      ready_mode = 0; lat_fixed = 0; spur_en = 1;
      for (int t = 0; t < 40; t++) begin
         clear_env();
         ld  = 1'($urandom_range(0, 1));
         n   = $urandom_range(0, 6);
         rfa = ($urandom_range(0, 3) == 0) ? 10'h3FC + 10'($urandom_range(0, 3)) : RAW'($urandom);
         sda = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFC0 : $urandom;
         d0 = done_cnt; errs = 0;
         start_op(ld, !ld, rfa, sda, LNW'(n), sc);
         wait_done(d0, n * 40 + 40, ok);
         checks++; if (!ok || done_cnt - d0 != 1) begin
            failures++; $display("FAIL rand[%0d]_done got=%0d want=1", t, done_cnt - d0);
         end
         checks++;
         if (q_sd_addr.size() != n || (ld ? (q_rfw_addr.size() != n || q_rfr_addr.size() != 0 || q_resp.size() != n)
                                          : (q_rfr_addr.size() != n || q_rfw_addr.size() != 0))) begin
            failures++; $display("FAIL rand[%0d]_counts ld=%0b sd=%0d rfw=%0d rfr=%0d want_n=%0d", t, ld, q_sd_addr.size(), q_rfw_addr.size(), q_rfr_addr.size(), n);
         end
         for (int i = 0; i < n && i < q_sd_addr.size(); i++) begin
            ea = rfa + 10'(i);
            es = sda + 32'(16 * i);
            if (q_sd_addr[i] !== es || q_sd_we[i] !== !ld) errs++;
            if (ld && i < q_rfw_addr.size() && i < q_resp.size() &&
                (q_rfw_addr[i] !== ea || q_rfw_data[i] !== q_resp[i])) errs++;
            if (!ld && i < q_rfr_addr.size() && (q_rfr_addr[i] !== ea || q_sd_wdata[i] !== rf_mem[ea])) errs++;
         end
         checks++; if (errs != 0) begin
            failures++; $display("FAIL rand[%0d]_lines ld=%0b rf=%h sd=%h n=%0d got_bad=%0d want=0", t, ld, rfa, sda, n, errs);
         end
         $display("rand[%0d] ld=%0b rf=%h sd=%h n=%0d lines=%0d", t, ld, rfa, sda, n, q_sd_addr.size());
      end
      spur_en = 0;
   endtask

   task automatic test_invariants();
      checks++; if (viol_both != 0) begin failures++; $display("FAIL we_re_overlap got=%0d want=0", viol_both); end
      checks++; if (viol_outst != 0) begin failures++; $display("FAIL outstanding got=%0d want=0", viol_outst); end
      checks++; if (viol_stable != 0) begin failures++; $display("FAIL req_stability got=%0d want=0", viol_stable); end
      checks++; if (viol_done != 0) begin failures++; $display("FAIL done_width got=%0d want=0", viol_done); end
      $display("test_invariants overlap=%0d outst=%0d unstable=%0d long_done=%0d", viol_both, viol_outst, viol_stable, viol_done);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) rf_mem[i] = rand128();
      test_reset();
      test_load();
      test_store(0);
      test_store(1);
      test_zero_len();
      test_simultaneous();
      test_reset_mid();
      test_random();
      test_invariants();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/rf_ldst_engine.md
RF_LDST_ENGINE -- requirements
Module: rf_ldst_engine

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning): RF_ADDR_W, 10, register-file line address width; LINE_NUM_W, 8, transfer length field width; SDRAM_ADDR_W, 32, SDRAM byte address width; LINE_W, 128, line data width.
REQ-002 The block SHALL use one clock, clk, and an asynchronous, active-low reset, rst_n.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- load_start  in  1  start SDRAM->RF transfer.
- store_start  in  1  start RF->SDRAM transfer.
- rf_addr  in  RF_ADDR_W  first RF line.
- sdram_addr  in  SDRAM_ADDR_W  first SDRAM byte address.
- line_num  in  LINE_NUM_W  number of lines to move.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- rf_we  out  1  RF write enable.
- rf_waddr  out  RF_ADDR_W  RF write address.
- rf_wdata  out  LINE_W  RF write data.
- rf_re  out  1  RF read enable.
- rf_raddr  out  RF_ADDR_W  RF read address.
- rf_rdata  in  LINE_W  RF read data, valid 1 cycle after rf_re.
- sd_req  out  1  SDRAM request valid.
- sd_we  out  1  1 = write, 0 = read.
- sd_addr  out  SDRAM_ADDR_W  SDRAM byte address.
- sd_wdata  out  LINE_W  SDRAM write data.
- sd_ready  in  1  SDRAM accepts request this cycle.
- sd_rvalid  in  1  read data valid.
- sd_rdata  in  LINE_W  read data.

Function
REQ-004 The FSM states SHALL be IDLE, LD_REQ, LD_WAIT, ST_RD, ST_REQ and DONE.
REQ-005 In IDLE, start inputs and operand fields SHALL be sampled into internal registers. Starts outside IDLE SHALL be ignored.
REQ-006 If load_start and store_start are both high in IDLE, load SHALL win.
REQ-007 A start with line_num==0 SHALL go directly to DONE with no RF or SDRAM traffic.
REQ-008 busy SHALL be high in every state except IDLE.
REQ-009 LD_REQ: sd_req=1, sd_we=0 and sd_addr=current address SHALL be held stable until sd_ready. The cycle in which sd_req and sd_ready are both high SHALL move the FSM to LD_WAIT.
REQ-010 LD_WAIT: on sd_rvalid, the block SHALL assert rf_we in that same cycle with rf_waddr=current RF address and rf_wdata=sd_rdata.
REQ-011 ST_RD: rf_re SHALL pulse for one cycle at the current RF address. The following cycle SHALL capture rf_rdata into sd_wdata and enter ST_REQ.
REQ-012 ST_REQ: sd_req=1 and sd_we=1 SHALL be held, with sd_addr and sd_wdata stable, until sd_ready.
REQ-013 After each completed line:
- RF address SHALL increment by 1, wrapping modulo 2^RF_ADDR_W.
- SDRAM address SHALL increment by LINE_W/8, wrapping modulo 2^SDRAM_ADDR_W.
- The remaining count SHALL decrement.
- The FSM SHALL go to DONE if the count reaches 0, else return to LD_REQ or ST_RD.
REQ-014 DONE SHALL assert done for exactly one cycle, then return to IDLE. A start may be accepted in the cycle after DONE.
REQ-015 At most one SDRAM request SHALL be outstanding.
REQ-016 sd_rvalid outside LD_WAIT SHALL be ignored.
REQ-017 rf_we and rf_re SHALL never be high in the same cycle.

Reset
REQ-018 On rst_n low, the following SHALL clear immediately: FSM to IDLE; busy, done, rf_we, rf_re, sd_req and sd_we to 0; all address, data and count registers to 0.
REQ-019 Reset mid-transfer SHALL abort with no done pulse. Any late sd_rvalid SHALL be dropped.

Structure
REQ-020 Package rf_ldst_pkg SHALL hold the state enum, the default widths and the LINE_BYTES constant (LINE_W/8).
REQ-021 Address and count stepping SHALL live in sub-module ldst_addr_gen (load, step, last outputs). The FSM and datapath SHALL stay in rf_ldst_engine.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Load: rf_addr=0x010, sdram_addr=0x1000, line_num=3, sd_ready always 1, rvalid 2 cycles after accept -> reads at 0x1000, 0x1010, 0x1020; RF writes at 0x010, 0x011, 0x012 with matching data; one done pulse.
- Store: rf_addr=0x3FE, line_num=3 -> RF reads 0x3FE, 0x3FF, 0x000 (wrap); SDRAM writes carry rf_rdata of each; done once.
- Back-pressure: sd_ready held 0 for 5 cycles on line 2 -> sd_req, sd_addr and sd_wdata remain stable; no extra requests.
- line_num=0 -> done exactly 2 cycles after start; sd_req and rf_we/rf_re never high.
- Simultaneous load_start and store_start, then store_start mid-load -> only the load executes; the second start is ignored.
- rst_n low in LD_WAIT, then sd_rvalid pulses -> all outputs 0; no rf_we; no done.
